// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbitration states and the
// request bundle that is muxed onto the single datamemory port.
package Arb_PKG;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_ADDR_W = 9;

    typedef enum logic [1:0] {
        CORE     = 2'd0,
        DBG_LOCK = 2'd1,
        YIELD    = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            func3;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the arbiter: core MEM-stage side, debug/loader side and the
// datamemory port. The arbiter uses the slave view, its environment the master view.
interface dmem_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  core_rd;
    logic                  core_wr;
    logic [DM_ADDRESS-1:0] core_addr;
    logic [DATA_W-1:0]     core_wdata;
    logic [2:0]            core_func3;
    logic [DATA_W-1:0]     core_rdata;
    logic                  core_stall;

    logic                  dbg_valid;
    logic                  dbg_we;
    logic                  dbg_lock;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic [2:0]            dbg_func3;
    logic                  dbg_ready;
    logic                  dbg_rvalid;
    logic [DATA_W-1:0]     dbg_rdata;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_func3;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  owner_dbg;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata, core_func3,
        output core_rdata, core_stall,
        input  dbg_valid, dbg_we, dbg_lock, dbg_addr, dbg_wdata, dbg_func3,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata,
        output owner_dbg
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata, core_func3,
        input  core_rdata, core_stall,
        output dbg_valid, dbg_we, dbg_lock, dbg_addr, dbg_wdata, dbg_func3,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        output mem_rdata,
        input  owner_dbg
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear. Clear and increment together load 1, so a
// counter can be restarted on the same cycle that counts the first event.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? ONE_V : '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + ONE_V;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the datamemory port between the MEM stage (default owner) and a
// debug/loader master with starvation guard and bounded locked bursts.
module dmem_arbiter
    import Arb_PKG::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MAX_WAIT   = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX_V  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BEAT_LAST_V = BW'(MAX_BURST - 1);

    arb_state_t    r_state, w_next;
    logic          w_core_req, w_starve, w_core_gnt, w_dbg_gnt;
    logic          w_wait_inc, w_wait_clr, w_beat_inc, w_beat_clr;
    logic [WW-1:0] w_wait_cnt;
    logic [BW-1:0] w_beat_cnt;
    mem_req_t      w_core, w_dbg, w_mem;
    logic          r_dbg_rvalid;
    logic [DATA_W-1:0] r_dbg_rdata;

    assign w_core_req = bus.core_rd | bus.core_wr;
    assign w_starve   = (w_wait_cnt == WAIT_MAX_V);

    always_ff @(posedge clk) begin
        if (reset) r_state <= CORE;
        else       r_state <= w_next;
    end

    // Grants are forced low during reset so no access leaks out in that cycle.
    always_comb begin
        w_next     = r_state;
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (!reset) begin
            unique case (r_state)
                CORE: begin
                    w_dbg_gnt  = bus.dbg_valid & (~w_core_req | w_starve);
                    w_core_gnt = w_core_req & ~w_dbg_gnt;
                    if (w_dbg_gnt && bus.dbg_lock)
                        w_next = (MAX_BURST == 1) ? YIELD : DBG_LOCK;
                end
                DBG_LOCK: begin
                    w_dbg_gnt = bus.dbg_valid;
                    if (!bus.dbg_lock || (w_dbg_gnt && (w_beat_cnt == BEAT_LAST_V)))
                        w_next = YIELD;
                end
                YIELD: begin
                    w_core_gnt = w_core_req;
                    w_next     = CORE;
                end
                default: w_next = CORE;
            endcase
        end
    end

    assign w_wait_inc = bus.dbg_valid & ~w_dbg_gnt;
    assign w_wait_clr = w_dbg_gnt | ~bus.dbg_valid | (w_next == YIELD);
    assign w_beat_inc = w_dbg_gnt & (w_next == DBG_LOCK);
    assign w_beat_clr = (r_state != DBG_LOCK) | (w_next != DBG_LOCK);

    sat_counter #(.W(WW), .MAX(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_wait_inc),
        .i_clr (w_wait_clr),
        .o_cnt (w_wait_cnt)
    );

    sat_counter #(.W(BW), .MAX(MAX_BURST)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_beat_inc),
        .i_clr (w_beat_clr),
        .o_cnt (w_beat_cnt)
    );

    always_comb begin
        w_core.rd    = bus.core_rd;
        w_core.wr    = bus.core_wr;
        w_core.addr  = ARB_ADDR_W'(bus.core_addr);
        w_core.wdata = ARB_DATA_W'(bus.core_wdata);
        w_core.func3 = bus.core_func3;
        w_dbg.rd     = ~bus.dbg_we;
        w_dbg.wr     = bus.dbg_we;
        w_dbg.addr   = ARB_ADDR_W'(bus.dbg_addr);
        w_dbg.wdata  = ARB_DATA_W'(bus.dbg_wdata);
        w_dbg.func3  = bus.dbg_func3;
        w_mem        = '0;
        if (w_core_gnt)     w_mem = w_core;
        else if (w_dbg_gnt) w_mem = w_dbg;
    end

    assign bus.mem_rd     = w_mem.rd;
    assign bus.mem_wr     = w_mem.wr;
    assign bus.mem_addr   = DM_ADDRESS'(w_mem.addr);
    assign bus.mem_wdata  = DATA_W'(w_mem.wdata);
    assign bus.mem_func3  = w_mem.func3;
    assign bus.core_rdata = w_core_gnt ? bus.mem_rdata : '0;
    assign bus.core_stall = w_core_req & ~w_core_gnt & ~reset;
    assign bus.dbg_ready  = w_dbg_gnt;
    assign bus.owner_dbg  = w_dbg_gnt;

    // Debug read data is captured at the accept edge and presented one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_dbg_rvalid <= w_dbg_gnt & ~bus.dbg_we;
            if (w_dbg_gnt && !bus.dbg_we)
                r_dbg_rdata <= bus.mem_rdata;
        end
    end

    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a rule-level reference model and a word memory.
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic        rst;
        logic        crd;
        logic        cwr;
        logic [8:0]  caddr;
        logic [31:0] cwd;
        logic        dv;
        logic        dwe;
        logic        dlk;
        logic [8:0]  daddr;
        logic [31:0] dwd;
    } stim_t;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

    dmem_arbiter #(
        .DATA_W     (32),
        .DM_ADDRESS (9),
        .MAX_WAIT   (MAX_WAIT),
        .MAX_BURST  (MAX_BURST)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tb_mem  [512];
    logic [31:0] ref_mem [512];
    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    stim_t cur;
    bit e_cg, e_dg;
    bit m_burst, m_yield, m_rvalid;
    int m_waited, m_beats;
    logic [31:0] m_rdata;

    logic        obs_stall, obs_ready, obs_rvalid, obs_mem_wr;
    logic [31:0] obs_rdata, obs_core_rdata, obs_wdata;
    logic [8:0]  obs_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_no, got, exp);
        end
    endtask

    task automatic apply_inputs();
        reset          = cur.rst;
        bus.core_rd    = cur.crd;
        bus.core_wr    = cur.cwr;
        bus.core_addr  = cur.caddr;
        bus.core_wdata = cur.cwd;
        bus.core_func3 = 3'b010;
        bus.dbg_valid  = cur.dv;
        bus.dbg_we     = cur.dwe;
        bus.dbg_lock   = cur.dlk;
        bus.dbg_addr   = cur.daddr;
        bus.dbg_wdata  = cur.dwd;
        bus.dbg_func3  = 3'b010;
    endtask

    task automatic check_outputs();
        bit creq;
        logic        x_rd, x_wr;
        logic [8:0]  x_addr;
        logic [31:0] x_wdata, x_crdata;
        creq = cur.crd | cur.cwr;
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (!cur.rst) begin
            if (m_yield) e_cg = creq;
            else if (m_burst) e_dg = cur.dv;
            else begin
                e_dg = cur.dv && (!creq || m_waited >= MAX_WAIT);
                e_cg = creq && !e_dg;
            end
        end
        x_rd = 1'b0; x_wr = 1'b0; x_addr = '0; x_wdata = '0; x_crdata = '0;
        if (e_cg) begin
            x_rd = cur.crd; x_wr = cur.cwr; x_addr = cur.caddr; x_wdata = cur.cwd;
            x_crdata = ref_mem[cur.caddr];
        end else if (e_dg) begin
            x_rd = !cur.dwe; x_wr = cur.dwe; x_addr = cur.daddr; x_wdata = cur.dwd;
        end
        chk("core_stall", 32'(bus.core_stall), 32'(!cur.rst && creq && !e_cg));
        chk("dbg_ready",  32'(bus.dbg_ready),  32'(e_dg));
        chk("owner_dbg",  32'(bus.owner_dbg),  32'(e_dg));
        chk("mem_rd",     32'(bus.mem_rd),     32'(x_rd));
        chk("mem_wr",     32'(bus.mem_wr),     32'(x_wr));
        chk("mem_addr",   32'(bus.mem_addr),   32'(x_addr));
        chk("mem_wdata",  bus.mem_wdata,       x_wdata);
        chk("core_rdata", bus.core_rdata,      x_crdata);
        chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(m_rvalid));
        chk("dbg_rdata",  bus.dbg_rdata,       m_rdata);
        obs_stall      = bus.core_stall;
        obs_ready      = bus.dbg_ready;
        obs_rvalid     = bus.dbg_rvalid;
        obs_rdata      = bus.dbg_rdata;
        obs_core_rdata = bus.core_rdata;
        obs_mem_wr     = bus.mem_wr;
        obs_addr       = bus.mem_addr;
        obs_wdata      = bus.mem_wdata;
    endtask

    task automatic model_advance();
        bit enter_yield;
        enter_yield = 1'b0;
        if (cur.rst) begin
            m_burst = 0; m_yield = 0; m_waited = 0; m_beats = 0;
            m_rvalid = 0; m_rdata = '0;
        end else begin
            m_rvalid = e_dg && !cur.dwe;
            if (m_rvalid) m_rdata = ref_mem[cur.daddr];
            if (e_cg && cur.cwr) ref_mem[cur.caddr] = cur.cwd;
            if (e_dg && cur.dwe) ref_mem[cur.daddr] = cur.dwd;
            if (m_yield) begin
                m_yield = 0;
            end else if (m_burst) begin
                if (e_dg) m_beats++;
                if (!cur.dlk || (e_dg && m_beats == MAX_BURST)) begin
                    m_burst = 0;
                    enter_yield = 1'b1;
                end
            end else if (e_dg && cur.dlk) begin
                m_beats = 1;
                if (MAX_BURST == 1) enter_yield = 1'b1;
                else m_burst = 1;
            end
            if (enter_yield) begin
                m_yield = 1;
                m_beats = 0;
            end
            if (enter_yield || e_dg || !cur.dv) m_waited = 0;
            else if (m_waited < MAX_WAIT) m_waited++;
        end
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        cur = s;
        apply_inputs();
        #1;
        check_outputs();
        @(posedge clk);
        if (obs_mem_wr === 1'b1) tb_mem[obs_addr] <= obs_wdata;
        model_advance();
        cyc_no++;
    endtask

    initial begin
        stim_t s;
        int n, beat, cyc;
        int acc [6];
        logic stall_log [100];
        logic ready_log [100];
        logic prev_stall, prev_hold;

        for (int i = 0; i < 512; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        m_burst = 0; m_yield = 0; m_waited = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
        cur = '0;
        cur.rst = 1'b1;
        apply_inputs();
        repeat (2) @(posedge clk);

        // reset state
        s = '0; s.rst = 1'b1; s.crd = 1'b1; s.dv = 1'b1;
        step(s);
        chk("rst_stall", 32'(obs_stall), 32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd0);

        // core-only store then load
        s = '0; s.cwr = 1'b1; s.caddr = 9'h010; s.cwd = 32'hDEADBEEF;
        step(s);
        chk("core_st_stall", 32'(obs_stall), 32'd0);
        s = '0; s.crd = 1'b1; s.caddr = 9'h010;
        step(s);
        chk("core_ld_stall", 32'(obs_stall), 32'd0);
        chk("core_ld_data", obs_core_rdata, 32'hDEADBEEF);

        // dbg-only read
        s = '0; s.dv = 1'b1; s.daddr = 9'h010;
        step(s);
        chk("dbg_rd_ready", 32'(obs_ready), 32'd1);
        s = '0;
        step(s);
        chk("dbg_rvalid_t1", 32'(obs_rvalid), 32'd1);
        chk("dbg_rdata_t1", obs_rdata, 32'hDEADBEEF);
        step(s);
        chk("dbg_rvalid_t2", 32'(obs_rvalid), 32'd0);

        // starvation guard: continuous core loads against a held dbg write
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            s = '0; s.crd = 1'b1; s.caddr = 9'h020;
            s.dv = 1'b1; s.dwe = 1'b1; s.daddr = 9'h030; s.dwd = 32'h1234_5678;
            step(s);
            if (obs_ready === 1'b1) begin
                n = c;
                break;
            end
            chk("starve_pre_stall", 32'(obs_stall), 32'd0);
        end
        chk("starve_cycle", 32'(n), 32'd9);
        chk("starve_stall", 32'(obs_stall), 32'd1);
        s = '0; s.crd = 1'b1; s.caddr = 9'h030;
        step(s);
        chk("starve_wr_data", obs_core_rdata, 32'h1234_5678);

        // locked burst of 6 writes with core loads held
        for (int i = 0; i < 6; i++) acc[i] = -1;
        beat = 0;
        cyc = 0;
        while (beat < 6 && cyc < 100) begin
            s = '0; s.crd = 1'b1; s.caddr = 9'h020;
            s.dv = 1'b1; s.dwe = 1'b1; s.dlk = 1'b1;
            s.daddr = 9'h040 + 9'(beat); s.dwd = 32'hB000_0000 + 32'(beat);
            step(s);
            stall_log[cyc] = obs_stall;
            ready_log[cyc] = obs_ready;
            if (obs_ready === 1'b1) begin
                acc[beat] = cyc;
                beat++;
            end
            cyc++;
        end
        chk("burst_beats", 32'(beat), 32'd6);
        chk("burst_first", 32'(acc[0]), 32'd8);
        chk("burst_consec", 32'(acc[3] - acc[0]), 32'd3);
        if (acc[3] >= 0 && acc[3] + 1 < cyc) begin
            chk("yield_stall", 32'(stall_log[acc[3] + 1]), 32'd0);
            chk("yield_no_dbg", 32'(ready_log[acc[3] + 1]), 32'd0);
        end else begin
            chk("yield_reached", 32'(acc[3]), 32'(-1 - 1));
        end
        chk("rearb_gap", 32'(acc[4] - acc[3]), 32'd9);
        chk("tail_consec", 32'(acc[5] - acc[4]), 32'd1);
        s = '0; s.crd = 1'b1; s.caddr = 9'h043;
        step(s);
        step(s);
        chk("burst_mem", obs_core_rdata, 32'hB000_0003);

        // reset in the middle of a locked burst
        s = '0; s.dv = 1'b1; s.dwe = 1'b1; s.dlk = 1'b1; s.daddr = 9'h050; s.dwd = 32'hA5A5_0000;
        step(s);
        s.dwe = 1'b0; s.daddr = 9'h043;
        step(s);
        chk("pre_rst_ready", 32'(obs_ready), 32'd1);
        s.rst = 1'b1; s.dwe = 1'b1; s.daddr = 9'h051; s.dwd = 32'hA5A5_0001;
        step(s);
        chk("rst_mem_wr", 32'(obs_mem_wr), 32'd0);
        chk("rst_owner", 32'(obs_ready), 32'd0);
        s = '0; s.crd = 1'b1; s.caddr = 9'h010;
        step(s);
        chk("post_rst_stall", 32'(obs_stall), 32'd0);
        chk("post_rst_rvalid", 32'(obs_rvalid), 32'd0);
        chk("post_rst_load", obs_core_rdata, 32'hDEADBEEF);

        // randomized traffic with pipeline-freeze and dbg-hold discipline
        s = '0;
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            int r;
            s.rst = ($urandom_range(0, 63) == 0);
            if (!prev_stall) begin
                r = $urandom_range(0, 3);
                s.crd   = (r == 1);
                s.cwr   = (r == 2);
                s.caddr = 9'($urandom_range(0, 15));
                s.cwd   = $urandom;
            end
            if (!prev_hold) begin
                s.dv    = ($urandom_range(0, 2) != 0);
                s.dwe   = $urandom_range(0, 1) == 1;
                s.daddr = 9'($urandom_range(0, 15));
                s.dwd   = $urandom;
            end
            s.dlk = ($urandom_range(0, 3) != 0);
            step(s);
            prev_stall = obs_stall;
            prev_hold  = s.dv && !obs_ready;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
